// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
package dmem_pkg;

  typedef enum logic [1:0] {
    SIZE_B   = 2'd0,
    SIZE_H   = 2'd1,
    SIZE_W   = 2'd2,
    SIZE_ILL = 2'd3
  } mem_size_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_e;

  // Byte-lane enables for a store of the given size at the given low address bits.
  function automatic logic [3:0] byte_en(input mem_size_e size, input logic [1:0] addr_lo);
    logic [3:0] be;
    be = 4'b0000;
    case (size)
      SIZE_B:  be = 4'b0001 << addr_lo;
      SIZE_H:  be = addr_lo[1] ? 4'b1100 : 4'b0011;
      SIZE_W:  be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Lane steering: store byte enables and data replication, load extraction and extension.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic        i_sign,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rword,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    o_be    = byte_en(mem_size_e'(i_size), i_addr_lo);
    o_wdata = 32'd0;
    o_rdata = 32'd0;
    w_byte  = 8'(i_rword >> {i_addr_lo, 3'b000});
    w_half  = i_addr_lo[1] ? i_rword[31:16] : i_rword[15:0];
    // i_sign = 1 selects zero extension (LBU/LHU)
    case (mem_size_e'(i_size))
      SIZE_B: begin
        o_wdata = {4{i_wdata[7:0]}};
        o_rdata = i_sign ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
      end
      SIZE_H: begin
        o_wdata = {2{i_wdata[15:0]}};
        o_rdata = i_sign ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
      end
      SIZE_W: begin
        o_wdata = i_wdata;
        o_rdata = i_rword;
      end
      default: begin
        o_wdata = 32'd0;
        o_rdata = 32'd0;
      end
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data-memory responder: fixed-latency byte/half/word loads and stores
// on a word-organised RAM behind a valid/ready request handshake.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        ReqValid,
  output logic        ReqReady,
  input  logic [31:0] Addr,
  input  logic        MemWrite,
  input  logic [1:0]  MemSize,
  input  logic        MemSign,
  input  logic [31:0] WData,
  output logic        RespValid,
  output logic [31:0] RData,
  output logic        RespErr
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam int unsigned CW = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;

  dmem_state_e   r_state;
  logic [CW-1:0] r_cnt;
  logic [31:0]   r_addr;
  logic [31:0]   r_wdata;
  logic          r_write;
  logic          r_sign;
  logic [1:0]    r_size;
  logic          r_resp_valid;
  logic [31:0]   r_rdata;
  logic          r_resp_err;
  logic [31:0]   r_mem [DEPTH_WORDS];

  logic [31:0]   w_addr;
  logic [31:0]   w_wdata;
  logic          w_write;
  logic          w_sign;
  logic [1:0]    w_size;
  logic          w_commit;
  logic          w_err;
  logic [AW-1:0] w_idx;
  logic [31:0]   w_rword;
  logic [3:0]    w_be;
  logic [31:0]   w_wdata_rep;
  logic [31:0]   w_load;

  // With LATENCY = 1 the commit edge is the accept edge, so use the live request fields there.
  always_comb begin
    w_addr  = r_addr;
    w_wdata = r_wdata;
    w_write = r_write;
    w_sign  = r_sign;
    w_size  = r_size;
    if (r_state == IDLE) begin
      w_addr  = Addr;
      w_wdata = WData;
      w_write = MemWrite;
      w_sign  = MemSign;
      w_size  = MemSize;
    end
    w_commit = 1'b0;
    if (r_state == IDLE)      w_commit = ReqValid && (LATENCY == 1);
    else if (r_state == WAIT) w_commit = (r_cnt == '0);
    w_idx   = w_addr[AW+1:2];
    w_err   = ((w_addr >> (AW + 2)) != 32'd0)
            || (w_size == SIZE_ILL)
            || ((w_size == SIZE_H) && w_addr[0])
            || ((w_size == SIZE_W) && (w_addr[1:0] != 2'b00));
    w_rword = r_mem[w_idx];
  end

  dmem_lane_align u_align (
    .i_size    (w_size),
    .i_sign    (w_sign),
    .i_addr_lo (w_addr[1:0]),
    .i_wdata   (w_wdata),
    .i_rword   (w_rword),
    .o_be      (w_be),
    .o_wdata   (w_wdata_rep),
    .o_rdata   (w_load)
  );

  // RAM is not reset; a write is suppressed on any edge where reset is asserted.
  always_ff @(posedge CLK) begin
    if (RST_N && w_commit && w_write && !w_err) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wdata_rep[8*i +: 8];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_resp_valid <= 1'b0;
      r_rdata      <= 32'd0;
      r_resp_err   <= 1'b0;
    end else begin
      r_resp_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (ReqValid) begin
            r_addr  <= Addr;
            r_wdata <= WData;
            r_write <= MemWrite;
            r_sign  <= MemSign;
            r_size  <= MemSize;
            if (LATENCY == 1) begin
              r_state <= RESP;
            end else begin
              r_cnt   <= CW'(LATENCY - 2);
              r_state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (r_cnt == '0) r_state <= RESP;
          else             r_cnt   <= r_cnt - CW'(1);
        end
        RESP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
      if (w_commit) begin
        r_resp_valid <= 1'b1;
        r_resp_err   <= w_err;
        r_rdata      <= (w_err || w_write) ? 32'd0 : w_load;
      end
    end
  end

  assign ReqReady  = RST_N && (r_state == IDLE);
  assign RespValid = r_resp_valid;
  assign RData     = r_rdata;
  assign RespErr   = r_resp_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: a LATENCY=2 instance for the main scenarios
// and a LATENCY=1 instance for the streaming back-to-back case.
module tb_dmem_responder;

  localparam int LAT = 2;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        req_valid, req_ready, mem_write, mem_sign, resp_valid, resp_err;
  logic [1:0]  mem_size;
  logic [31:0] addr, wdata, rdata;
  logic        v1_req_valid, v1_req_ready, v1_mem_write, v1_mem_sign, v1_resp_valid, v1_resp_err;
  logic [1:0]  v1_mem_size;
  logic [31:0] v1_addr, v1_wdata, v1_rdata;

  exp_t sb[$];
  exp_t sb1[$];
  int   checks = 0;
  int   errors = 0;

  always #5 CLK = ~CLK;

  dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(LAT)) u_dut (
    .CLK(CLK), .RST_N(RST_N), .ReqValid(req_valid), .ReqReady(req_ready), .Addr(addr),
    .MemWrite(mem_write), .MemSize(mem_size), .MemSign(mem_sign), .WData(wdata),
    .RespValid(resp_valid), .RData(rdata), .RespErr(resp_err)
  );

  dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(1)) u_dut1 (
    .CLK(CLK), .RST_N(RST_N), .ReqValid(v1_req_valid), .ReqReady(v1_req_ready), .Addr(v1_addr),
    .MemWrite(v1_mem_write), .MemSize(v1_mem_size), .MemSign(v1_mem_sign), .WData(v1_wdata),
    .RespValid(v1_resp_valid), .RData(v1_rdata), .RespErr(v1_resp_err)
  );

  // One transaction on the LATENCY=2 instance: drive, push expectation, wait, pop and compare.
  task automatic do_req(input string name, input logic wr, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] exp_d, input logic exp_e);
    exp_t e;
    bit   acc;
    bit   seen;
    int   lat;
    @(posedge CLK); #1;
    req_valid = 1'b1; mem_write = wr; mem_size = sz; mem_sign = sg; addr = a; wdata = wd;
    acc = 1'b0;
    for (int i = 0; i < 20 && !acc; i++) begin
      @(negedge CLK);
      if (req_ready === 1'b1) acc = 1'b1;
    end
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL %s accept: ReqReady=%b, required 1", name, req_ready);
      req_valid = 1'b0;
      return;
    end
    @(posedge CLK);
    e.rdata = exp_d; e.err = exp_e;
    sb.push_back(e);
    #1 req_valid = 1'b0;
    seen = 1'b0;
    lat  = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge CLK);
      lat++;
      if (resp_valid === 1'b1) seen = 1'b1;
      checks++;
      if (req_ready !== 1'b0) begin
        errors++;
        $display("FAIL %s busy_ready: ReqReady=%b at cycle %0d, required 0", name, req_ready, lat);
      end
    end
    checks++;
    if (lat !== LAT) begin
      errors++;
      $display("FAIL %s latency: got %0d cycles, required %0d", name, lat, LAT);
    end
    if (seen) begin
      e = sb.pop_front();
      checks++;
      if (rdata !== e.rdata || resp_err !== e.err) begin
        errors++;
        $display("FAIL %s data: RData=%h RespErr=%b, required RData=%h RespErr=%b",
                 name, rdata, resp_err, e.rdata, e.err);
      end
      @(negedge CLK);
      checks++;
      if (resp_valid !== 1'b0) begin
        errors++;
        $display("FAIL %s strobe: RespValid=%b one cycle later, required 0", name, resp_valid);
      end
    end
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    req_valid = 1'b0; mem_write = 1'b0; mem_size = 2'd0; mem_sign = 1'b0; addr = '0; wdata = '0;
    v1_req_valid = 1'b0; v1_mem_write = 1'b0; v1_mem_size = 2'd0; v1_mem_sign = 1'b0;
    v1_addr = '0; v1_wdata = '0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    checks++;
    if (req_ready !== 1'b0 || resp_valid !== 1'b0 || rdata !== 32'd0 || resp_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: ready=%b valid=%b rdata=%h err=%b, required 0 0 00000000 0",
               req_ready, resp_valid, rdata, resp_err);
    end
    @(posedge CLK); #1 RST_N = 1'b1;
    @(negedge CLK);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: ReqReady=%b, required 1", req_ready);
    end
  endtask

  task automatic test_word();
    do_req("sw_10", 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
    do_req("lw_10", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
  endtask

  task automatic test_byte_loads();
    do_req("sw_20",  1'b1, 2'd2, 1'b0, 32'h20, 32'h80FF7F01, 32'h0, 1'b0);
    do_req("lb_23",  1'b0, 2'd0, 1'b0, 32'h23, 32'h0, 32'hFFFFFF80, 1'b0);
    do_req("lbu_23", 1'b0, 2'd0, 1'b1, 32'h23, 32'h0, 32'h00000080, 1'b0);
    do_req("lb_20",  1'b0, 2'd0, 1'b0, 32'h20, 32'h0, 32'h00000001, 1'b0);
    do_req("lb_22",  1'b0, 2'd0, 1'b0, 32'h22, 32'h0, 32'hFFFFFFFF, 1'b0);
  endtask

  task automatic test_half();
    do_req("sw_fill", 1'b1, 2'd2, 1'b0, 32'h20, 32'h11111111, 32'h0, 1'b0);
    do_req("sh_22",   1'b1, 2'd1, 1'b0, 32'h22, 32'h1234ABCD, 32'h0, 1'b0);
    do_req("lw_20h",  1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 32'hABCD1111, 1'b0);
    do_req("lh_22",   1'b0, 2'd1, 1'b0, 32'h22, 32'h0, 32'hFFFFABCD, 1'b0);
    do_req("lhu_22",  1'b0, 2'd1, 1'b1, 32'h22, 32'h0, 32'h0000ABCD, 1'b0);
  endtask

  task automatic test_errors();
    do_req("sw_30",    1'b1, 2'd2, 1'b0, 32'h30, 32'hA5A5A5A5, 32'h0, 1'b0);
    do_req("sw_00",    1'b1, 2'd2, 1'b0, 32'h00, 32'h0BADF00D, 32'h0, 1'b0);
    do_req("lw_mis",   1'b0, 2'd2, 1'b0, 32'h31, 32'h0, 32'h0, 1'b1);
    do_req("sh_mis",   1'b1, 2'd1, 1'b0, 32'h33, 32'h0000FFFF, 32'h0, 1'b1);
    do_req("lw_30a",   1'b0, 2'd2, 1'b0, 32'h30, 32'h0, 32'hA5A5A5A5, 1'b0);
    do_req("sz_ill",   1'b1, 2'd3, 1'b0, 32'h30, 32'hFFFFFFFF, 32'h0, 1'b1);
    do_req("lw_30b",   1'b0, 2'd2, 1'b0, 32'h30, 32'h0, 32'hA5A5A5A5, 1'b0);
    do_req("sw_oob",   1'b1, 2'd2, 1'b0, 32'h1000, 32'h12345678, 32'h0, 1'b1);
    do_req("lw_00",    1'b0, 2'd2, 1'b0, 32'h00, 32'h0, 32'h0BADF00D, 1'b0);
  endtask

  task automatic test_reset_mid_op();
    bit acc;
    do_req("sw_40", 1'b1, 2'd2, 1'b0, 32'h40, 32'h00000077, 32'h0, 1'b0);
    @(posedge CLK); #1;
    req_valid = 1'b1; mem_write = 1'b1; mem_size = 2'd2; mem_sign = 1'b0; addr = 32'h40; wdata = 32'h5;
    acc = 1'b0;
    for (int i = 0; i < 20 && !acc; i++) begin
      @(negedge CLK);
      if (req_ready === 1'b1) acc = 1'b1;
    end
    @(posedge CLK); #1 req_valid = 1'b0;
    @(negedge CLK);
    RST_N = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      checks++;
      if (resp_valid !== 1'b0 || req_ready !== 1'b0) begin
        errors++;
        $display("FAIL rst_mid cycle %0d: RespValid=%b ReqReady=%b, required 0 0",
                 c, resp_valid, req_ready);
      end
    end
    @(posedge CLK); #1 RST_N = 1'b1;
    do_req("lw_40", 1'b0, 2'd2, 1'b0, 32'h40, 32'h0, 32'h00000077, 1'b0);
  endtask

  // LATENCY=1 instance with ReqValid held high across four requests.
  task automatic test_back_to_back();
    logic        tw [4];
    logic [1:0]  tsz[4];
    logic [31:0] ta [4];
    logic [31:0] twd[4];
    logic [31:0] td [4];
    tw  = '{1'b1, 1'b0, 1'b1, 1'b0};
    tsz = '{2'd2, 2'd2, 2'd0, 2'd2};
    ta  = '{32'h8, 32'h8, 32'h9, 32'h8};
    twd = '{32'h11223344, 32'h0, 32'h00000099, 32'h0};
    td  = '{32'h0, 32'h11223344, 32'h0, 32'h11229944};
    fork
      begin
        bit ok;
        exp_t e;
        @(posedge CLK); #1;
        v1_req_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
          v1_mem_write = tw[k]; v1_mem_size = tsz[k]; v1_mem_sign = 1'b0;
          v1_addr = ta[k]; v1_wdata = twd[k];
          ok = 1'b0;
          for (int i = 0; i < 10 && !ok; i++) begin
            @(negedge CLK);
            if (v1_req_ready === 1'b1) ok = 1'b1;
          end
          if (ok) begin
            @(posedge CLK);
            e.rdata = td[k]; e.err = 1'b0;
            sb1.push_back(e);
            #1;
          end
        end
        v1_req_valid = 1'b0;
      end
      begin
        exp_t e;
        int   got;
        int   last;
        got  = 0;
        last = -1;
        for (int c = 0; c < 40 && got < 4; c++) begin
          @(negedge CLK);
          if (v1_resp_valid === 1'b1) begin
            checks++;
            if (sb1.size() == 0) begin
              errors++;
              $display("FAIL b2b unexpected response at cycle %0d: RData=%h", c, v1_rdata);
            end else begin
              e = sb1.pop_front();
              if (v1_rdata !== e.rdata || v1_resp_err !== e.err) begin
                errors++;
                $display("FAIL b2b resp %0d: RData=%h RespErr=%b, required RData=%h RespErr=%b",
                         got, v1_rdata, v1_resp_err, e.rdata, e.err);
              end
            end
            if (last >= 0) begin
              checks++;
              if (c - last !== 2) begin
                errors++;
                $display("FAIL b2b spacing: %0d cycles between responses, required 2", c - last);
              end
            end
            last = c;
            got++;
          end
        end
        checks++;
        if (got !== 4) begin
          errors++;
          $display("FAIL b2b count: got %0d responses, required 4", got);
        end
      end
    join
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte_loads();
    test_half();
    test_errors();
    test_reset_mid_op();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
